// File: rtl/spm_pkg.sv
// Shared types and defaults for the SPM unified program/data memory.
package spm_pkg;

  localparam int SPM_ADDR_W = 8;
  localparam int SPM_DATA_W = 8;

  typedef enum logic [1:0] {
    MEM_LOAD    = 2'd0,
    MEM_RELEASE = 2'd1,
    MEM_RUN     = 2'd2
  } spm_mem_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spm_memory_if.sv
// SPM memory bus: processor read/write port plus the byte-wide program loader handshake.
interface spm_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;

  modport master (
    output address, data_out, write, load_valid, load_data, load_last,
    input  data_in, load_ready
  );

  modport slave (
    input  address, data_out, write, load_valid, load_data, load_last,
    output data_in, load_ready
  );
endinterface

// File: rtl/spm_mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, never cleared.
module spm_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spm_memory.sv
// SPM memory endpoint: loads a program image, then releases the processor and serves it.
// Define SPM_MEM_PROTECT_EN to drop processor writes below PROT_LIMIT and flag them.
module spm_memory
  import spm_pkg::*;
#(
  parameter int                ADDR_W     = SPM_ADDR_W,
  parameter int                DATA_W     = SPM_DATA_W,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(8'h80)
) (
  input  logic              clk,
  input  logic              rst,
  spm_memory_if.slave       bus,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   loaded_len,
  output logic [15:0]       wr_count,
  output logic              prot_viol
);

`ifdef SPM_MEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  spm_mem_state_t    state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_W:0]   loaded_len_q, loaded_len_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              load_ready_q, load_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              prot_viol_q, prot_viol_d;

  logic              load_fire;
  logic              prot_hit;
  logic              cpu_wr_req;
  logic              cpu_commit;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign load_fire  = (state_q == MEM_LOAD) && bus.load_valid && load_ready_q;
  assign prot_hit   = PROT_EN && (bus.address < PROT_LIMIT);
  assign cpu_wr_req = (state_q == MEM_RUN) && bus.write;
  assign cpu_commit = cpu_wr_req && !prot_hit;

  // The single write port belongs to the loader in MEM_LOAD and to the processor otherwise.
  assign arr_we    = load_fire || cpu_commit;
  assign arr_waddr = (state_q == MEM_LOAD) ? load_ptr_q    : bus.address;
  assign arr_wdata = (state_q == MEM_LOAD) ? bus.load_data : bus.data_out;

  spm_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (bus.address),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    loaded_len_d = loaded_len_q;
    wr_count_d   = wr_count_q;
    load_ready_d = load_ready_q;
    cpu_rst_d    = cpu_rst_q;
    prot_viol_d  = prot_viol_q;
    case (state_q)
      MEM_LOAD: begin
        load_ready_d = 1'b1;
        cpu_rst_d    = 1'b0;
        if (load_fire) begin
          load_ptr_d   = load_ptr_q + ADDR_W'(1);
          loaded_len_d = loaded_len_q + (ADDR_W+1)'(1);
          // A full array ends the load even if the loader never flags its last byte.
          if (bus.load_last || (load_ptr_q == '1)) begin
            state_d      = MEM_RELEASE;
            load_ready_d = 1'b0;
          end
        end
      end
      MEM_RELEASE: begin
        state_d      = MEM_RUN;
        load_ready_d = 1'b0;
        cpu_rst_d    = 1'b0;
      end
      MEM_RUN: begin
        load_ready_d = 1'b0;
        cpu_rst_d    = 1'b1;
        if (cpu_commit) wr_count_d = sat_inc16(wr_count_q);
        if (cpu_wr_req && prot_hit) prot_viol_d = 1'b1;
      end
      default: begin
        state_d      = MEM_LOAD;
        load_ready_d = 1'b0;
        cpu_rst_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= MEM_LOAD;
      load_ptr_q   <= '0;
      loaded_len_q <= '0;
      wr_count_q   <= '0;
      load_ready_q <= 1'b0;
      cpu_rst_q    <= 1'b0;
      prot_viol_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      loaded_len_q <= loaded_len_d;
      wr_count_q   <= wr_count_d;
      load_ready_q <= load_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      prot_viol_q  <= prot_viol_d;
    end
  end

  assign bus.data_in    = arr_rdata;
  assign bus.load_ready = load_ready_q;
  assign cpu_rst        = cpu_rst_q;
  assign loaded_len     = loaded_len_q;
  assign wr_count       = wr_count_q;
  assign prot_viol      = PROT_EN ? prot_viol_q : 1'b0;

endmodule

// File: doc/spm_memory.md
# spm_memory

Unified program/data memory that serves as the responder end of the SPM memory bus driven by the RISC_SPM processor. After reset it accepts a program image over a byte-wide valid/ready loader port while holding the processor in reset. It then releases the processor and serves its reads and writes. It replaces ad-hoc bench memories, giving the processor bench one synthesizable, self-checking memory endpoint.

## Interface
Parameters:
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- DATA_W, 8, word width
- PROT_LIMIT, 8'h80, first writable address when protection is compiled in

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- address  in  ADDR_W  processor address
- data_out  in  DATA_W  processor write data
- write  in  1  processor write strobe, sampled at clk rise
- data_in  out  DATA_W  read data to processor
- load_valid  in  1  loader byte valid
- load_data  in  DATA_W  loader byte
- load_last  in  1  marks final loader byte
- load_ready  out  1  loader may transfer
- cpu_rst  out  1  active-low reset to processor
- loaded_len  out  ADDR_W+1  bytes accepted in the last load
- wr_count  out  16  processor writes committed since reset
- prot_viol  out  1  sticky protection violation (macro only; else tied 0)

## Operation
- FSM states: MEM_LOAD, MEM_RELEASE, MEM_RUN.
- Reset enters MEM_LOAD. Memory array contents are not cleared.
- MEM_LOAD:
  - load_ready=1, cpu_rst=0.
  - Each cycle with load_valid&&load_ready writes load_data to mem[load_ptr], then load_ptr++ and loaded_len++.
  - The transfer with load_last=1 moves the FSM to MEM_RELEASE.
  - A transfer at load_ptr=2**ADDR_W-1 also moves to MEM_RELEASE, regardless of load_last.
  - Processor write is ignored.
- MEM_RELEASE:
  - Lasts exactly one cycle, then goes to MEM_RUN.
  - load_ready=0, cpu_rst=0.
- MEM_RUN:
  - cpu_rst=1, load_ready=0.
  - load_valid is ignored.
  - write=1 commits data_out to mem[address] and increments wr_count. wr_count saturates at 16'hFFFF.
- Reads in all states: data_in = mem[address], combinational (asynchronous read).
- A read of an address written in the same cycle returns old data until the edge, and new data after it.
- loaded_len holds its value through MEM_RUN. It clears only on reset.
- Reset mid-load or mid-run:
  - Returns to MEM_LOAD with load_ptr=0, loaded_len=0, wr_count=0.
  - cpu_rst drops asynchronously with rst.

## Timing
- Reset values:
  - load_ready=0, cpu_rst=0, loaded_len=0, wr_count=0, prot_viol=0.
  - data_in is not reset; it tracks mem[address].
- load_ready, cpu_rst and wr_count are registered outputs.
- load_ready rises on the first clk edge after rst deasserts.
- Loader transfer completes on the edge where load_valid&&load_ready. The byte is readable via data_in after that edge.
- Accepting load_last at edge N gives:
  - load_ready=0 after edge N
  - state MEM_RELEASE during N..N+1
  - cpu_rst=1 after edge N+2
- Write latency is one edge. wr_count updates on the same edge as the write.

## Configuration
- SPM_MEM_PROTECT_EN defined:
  - In MEM_RUN, a processor write with address < PROT_LIMIT is dropped and does not count in wr_count.
  - The same write sets prot_viol, which stays set until reset.
  - Loader writes are never protected.
- SPM_MEM_PROTECT_EN undefined: all processor writes commit, and prot_viol is tied 0.

## Structure
- spm_pkg holds:
  - enum spm_mem_state_t {MEM_LOAD, MEM_RELEASE, MEM_RUN}
  - localparams SPM_ADDR_W=8 and SPM_DATA_W=8, used as parameter defaults
- Sub-module spm_mem_array holds the storage.
  - One synchronous write port, muxed between loader and processor by state.
  - One asynchronous read port.
- spm_memory keeps the FSM, pointer, counters and protection logic.

## Test plan
- Load 3 bytes (8'h11, 8'h22, 8'h33 with load_last on the third) -> loaded_len=3, load_ready low after the third edge, cpu_rst high exactly 2 edges later, data_in=8'h22 at address 1.
- Full load of 256 bytes with load_last never asserted -> FSM leaves MEM_LOAD after byte 255, loaded_len=256, the next load_valid is ignored.
- In MEM_RUN, write 8'hA5 to address 8'hF0 -> data_in=8'hA5 after the edge, wr_count=1. A write with write=0 leaves memory unchanged.
- Assert rst mid-load after 2 bytes, then reload 1 byte 8'h7E -> cpu_rst low immediately, loaded_len=1, mem[0]=8'h7E, mem[1] keeps its prior byte.
- With SPM_MEM_PROTECT_EN, write to 8'h10 in MEM_RUN -> mem[8'h10] unchanged, prot_viol=1, wr_count=0. A write to 8'h90 commits and gives wr_count=1.
- load_valid held high with load_ready=0 during MEM_RUN -> no array change, loaded_len stable.
